si_tag_packetizer: RTL and testbench

SI_TAG_PACKETIZER -- requirements
Module: si_tag_packetizer

---
 rtl/si_tag_packetizer.sv | 180 ++++++++++++++++++
 tb/tb_si_tag_packetizer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/si_tag_packetizer.sv
// Packs a 32-bit tag stream into 128-bit frames. Each frame starts with a header beat
// carrying the sequence number and the rollover time shared by every tag in the frame.
module si_tag_packetizer #(
  parameter int DATA_WIDTH_OUT = 128,
  parameter int MAX_TAGS       = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [31:0]  s_axis_tdata,
  input  logic [31:0]  s_axis_tuser,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [127:0] m_axis_tdata,
  output logic [15:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [31:0]  seq_num,
  output logic         frame_done
);
  if (DATA_WIDTH_OUT != 128) begin : g_bad_width
    $error("si_tag_packetizer: DATA_WIDTH_OUT must be 128");
  end
  if (MAX_TAGS < 4 || MAX_TAGS > 4096 || (MAX_TAGS % 4) != 0) begin : g_bad_tags
    $error("si_tag_packetizer: MAX_TAGS must be a multiple of 4 in 4..4096");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("si_tag_packetizer: TIMEOUT_CYCLES must be at least 1");
  end

  localparam int TOT_W = $clog2(MAX_TAGS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOT_W-1:0] LAST_TAG_IDX = TOT_W'(MAX_TAGS - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [15:0]      HDR_MAGIC    = 16'h5349;

  typedef enum logic [1:0] {IDLE, HEADER, COLLECT, DRAIN} state_t;

  state_t             r_state;
  logic [31:0]        r_rollover;
  logic [31:0]        r_seq;
  logic [TOT_W-1:0]   r_total;
  logic [TO_W-1:0]    r_timeout;
  logic [31:0]        r_acc [4];
  logic [2:0]         r_acc_cnt;
  logic               r_m_tvalid;
  logic [127:0]       r_m_tdata;
  logic [15:0]        r_m_tkeep;
  logic               r_m_tlast;

  logic               w_out_free;
  logic               w_acc_full;
  logic               w_first;
  logic               w_match;
  logic               w_tready;
  logic               w_accept;
  logic               w_mismatch;
  logic               w_last_tag;
  logic               w_tlast_hs;
  logic [31:0]        w_seq_cur;
  logic [TO_W-1:0]    w_to_next;
  logic [3:0]         w_lane_used;
  logic [127:0]       w_acc_data;
  logic [15:0]        w_acc_keep;

  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_acc_full = (r_acc_cnt == 3'd4);
  assign w_first    = (r_total == '0);
  assign w_match    = (s_axis_tuser == r_rollover);
  // A tag with a foreign rollover is refused outright so it can open the next frame.
  assign w_tready   = (r_state == COLLECT) && (!w_acc_full || w_out_free) && (w_first || w_match);
  assign w_accept   = s_axis_tvalid && w_tready;
  assign w_mismatch = (r_state == COLLECT) && s_axis_tvalid && !w_first && !w_match;
  assign w_last_tag = (r_total == LAST_TAG_IDX);
  assign w_tlast_hs = r_m_tvalid && m_axis_tready && r_m_tlast;
  assign w_seq_cur  = w_tlast_hs ? r_seq + 32'd1 : r_seq;
  assign w_to_next  = (r_timeout == TO_LIMIT) ? r_timeout : r_timeout + TO_W'(1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane_used[gi]        = (r_acc_cnt > 3'(gi));
    assign w_acc_data[32*gi +: 32] = w_lane_used[gi] ? r_acc[gi] : 32'h0;
    assign w_acc_keep[4*gi +: 4]   = {4{w_lane_used[gi]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rollover <= 32'h0;
      r_seq      <= 32'h0;
      r_total    <= '0;
      r_timeout  <= '0;
      for (int i = 0; i < 4; i++) r_acc[i] <= 32'h0;
      r_acc_cnt  <= 3'd0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= 128'h0;
      r_m_tkeep  <= 16'h0;
      r_m_tlast  <= 1'b0;
    end else begin
      if (r_m_tvalid && m_axis_tready) r_m_tvalid <= 1'b0;
      if (w_tlast_hs) r_seq <= r_seq + 32'd1;

      case (r_state)
        IDLE: begin
          if (s_axis_tvalid && w_out_free) begin
            r_rollover <= s_axis_tuser;
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= {48'h0, HDR_MAGIC, s_axis_tuser, w_seq_cur};
            r_m_tkeep  <= 16'hFFFF;
            r_m_tlast  <= 1'b0;
            r_state    <= HEADER;
          end
        end
        HEADER: begin
          if (m_axis_tready) begin
            r_timeout <= '0;
            r_total   <= '0;
            r_state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_timeout <= '0;
            r_total   <= r_total + TOT_W'(1);
            if (w_last_tag) begin
              // The final tag always completes a 4-tag beat; ship it straight out when possible.
              r_state <= DRAIN;
              if (w_out_free) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= {s_axis_tdata, r_acc[2], r_acc[1], r_acc[0]};
                r_m_tkeep  <= 16'hFFFF;
                r_m_tlast  <= 1'b1;
                r_acc_cnt  <= 3'd0;
              end else begin
                r_acc[3]  <= s_axis_tdata;
                r_acc_cnt <= 3'd4;
              end
            end else if (w_acc_full) begin
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_acc_data;
              r_m_tkeep  <= 16'hFFFF;
              r_m_tlast  <= 1'b0;
              r_acc[0]   <= s_axis_tdata;
              r_acc_cnt  <= 3'd1;
            end else begin
              r_acc[r_acc_cnt[1:0]] <= s_axis_tdata;
              r_acc_cnt             <= r_acc_cnt + 3'd1;
            end
          end else if (w_mismatch) begin
            r_state <= DRAIN;
          end else if (!s_axis_tvalid) begin
            r_timeout <= w_to_next;
            if (w_to_next == TO_LIMIT && !w_first) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_acc_cnt == 3'd0) begin
            r_state <= IDLE;
          end else if (w_out_free) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_acc_data;
            r_m_tkeep  <= w_acc_keep;
            r_m_tlast  <= 1'b1;
            r_acc_cnt  <= 3'd0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign seq_num       = r_seq;
  assign frame_done    = w_tlast_hs;
endmodule

// File: tb/tb_si_tag_packetizer.sv
// Scoreboard bench for si_tag_packetizer with MAX_TAGS=8, TIMEOUT_CYCLES=16: full frame,
// rollover change, timeout close, random backpressure and a mid-frame reset.
module tb_si_tag_packetizer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = 32'h0;
  logic [31:0]  s_user = 32'h0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [127:0] m_data;
  logic [15:0]  m_keep;
  logic         m_last;
  logic [31:0]  seq;
  logic         fdone;

  si_tag_packetizer #(.DATA_WIDTH_OUT(128), .MAX_TAGS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tkeep(m_keep), .m_axis_tlast(m_last), .seq_num(seq), .frame_done(fdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    bit           hdr;
  } beat_t;

  beat_t exp_q[$];
  int n_vec = 0, n_miss = 0;
  int n_acc = 0, n_out_tags = 0, n_fd = 0, cyc = 0;
  int acc_cyc = 0, last_cyc = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk_hdr(input logic [31:0] s, input logic [31:0] r);
    beat_t b;
    b.data = {48'h0, 16'h5349, r, s};
    b.keep = 16'hFFFF;
    b.last = 1'b0;
    b.hdr  = 1'b1;
    return b;
  endfunction

  function automatic beat_t mk_pay(input logic [31:0] t0, input logic [31:0] t1,
                                   input logic [31:0] t2, input logic [31:0] t3,
                                   input logic [15:0] keep, input logic last);
    beat_t b;
    b.data = {t3, t2, t1, t0};
    b.keep = keep;
    b.last = last;
    b.hdr  = 1'b0;
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] u);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_user  = u;
    forever begin
      #1;
      hs = s_ready;
      @(posedge clk);
      if (hs) break;
      n++;
      if (n > 300) begin
        n_vec++;
        n_miss++;
        $display("FAIL send_timeout: got no accept of tag %h, required accept within 300 cycles", d);
        break;
      end
      @(negedge clk);
    end
    #1;
    s_valid = 1'b0;
    if (hs) begin
      n_acc++;
      acc_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    beat_t        e;
    bit           stall;
    logic [127:0] pd;
    logic [15:0]  pk;
    logic         pl;
    stall = 1'b0;
    pd = '0; pk = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_vec++;
          if (!m_valid || m_data !== pd || m_keep !== pk || m_last !== pl) begin
            n_miss++;
            $display("FAIL stall_stable: got v=%b d=%h k=%h l=%b required v=1 d=%h k=%h l=%b",
                     m_valid, m_data, m_keep, m_last, pd, pk, pl);
          end
        end
        if (fdone) n_fd++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL extra_beat: got d=%h k=%h l=%b required no beat", m_data, m_keep, m_last);
          end else begin
            e = exp_q.pop_front();
            n_vec++;
            if (m_data !== e.data || m_keep !== e.keep || m_last !== e.last) begin
              n_miss++;
              $display("FAIL beat: got d=%h k=%h l=%b required d=%h k=%h l=%b",
                       m_data, m_keep, m_last, e.data, e.keep, e.last);
            end else begin
              $display("beat %s d=%h k=%h l=%b", e.hdr ? "hdr" : "pay", m_data, m_keep, m_last);
            end
            if (!e.hdr) begin
              if (!e.last) begin
                n_vec++;
                if (n_acc <= n_out_tags + 4) begin
                  n_miss++;
                  $display("FAIL hold_until_next: got %0d tags accepted, required more than %0d",
                           n_acc, n_out_tags + 4);
                end
              end
              n_out_tags += $countones(e.keep) / 4;
            end
            if (m_last) last_cyc = cyc;
          end
        end
        stall = m_valid && !m_ready;
        pd = m_data;
        pk = m_keep;
        pl = m_last;
      end
    end
  end

  initial begin
    int fd0;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_seq", seq, 0);
    chk("rst_frame_done", fdone, 0);
    rst = 1'b0;

    // Full frame of 8 tags closes on the tag count.
    fd0 = n_fd;
    exp_q.push_back(mk_hdr(32'd0, 32'h100));
    exp_q.push_back(mk_pay(32'd1, 32'd2, 32'd3, 32'd4, 16'hFFFF, 1'b0));
    exp_q.push_back(mk_pay(32'd5, 32'd6, 32'd7, 32'd8, 16'hFFFF, 1'b1));
    for (int i = 1; i <= 8; i++) send(32'(i), 32'h100);
    wait_drain("frame_full");
    chk("seq_after_full", seq, 1);
    chk("frame_done_count", 32'(n_fd - fd0), 1);

    // Rollover change closes the frame; the refused tag opens the next one.
    exp_q.push_back(mk_hdr(32'd1, 32'h100));
    exp_q.push_back(mk_pay(32'h11, 32'h12, 32'h0, 32'h0, 16'h00FF, 1'b1));
    exp_q.push_back(mk_hdr(32'd2, 32'h101));
    exp_q.push_back(mk_pay(32'h13, 32'h0, 32'h0, 32'h0, 16'h000F, 1'b1));
    send(32'h11, 32'h100);
    send(32'h12, 32'h100);
    send(32'h13, 32'h101);
    wait_drain("rollover_change");
    chk("seq_after_rollover", seq, 3);

    // Five tags then silence: the partial beat leaves after the timeout.
    exp_q.push_back(mk_hdr(32'd3, 32'h200));
    exp_q.push_back(mk_pay(32'h21, 32'h22, 32'h23, 32'h24, 16'hFFFF, 1'b0));
    exp_q.push_back(mk_pay(32'h25, 32'h0, 32'h0, 32'h0, 16'h000F, 1'b1));
    for (int i = 0; i < 5; i++) send(32'h21 + 32'(i), 32'h200);
    wait_drain("timeout_close");
    lat = last_cyc - acc_cyc;
    n_vec++;
    if (lat < 16 || lat > 18) begin
      n_miss++;
      $display("FAIL timeout_latency: got %0d cycles, required 16..18", lat);
    end

    // Random output backpressure and input gaps, 20 frames of 8 tags.
    for (int f = 0; f < 20; f++) begin
      exp_q.push_back(mk_hdr(32'(4 + f), 32'h300));
      exp_q.push_back(mk_pay(32'h1000 + 32'(8*f), 32'h1001 + 32'(8*f),
                             32'h1002 + 32'(8*f), 32'h1003 + 32'(8*f), 16'hFFFF, 1'b0));
      exp_q.push_back(mk_pay(32'h1004 + 32'(8*f), 32'h1005 + 32'(8*f),
                             32'h1006 + 32'(8*f), 32'h1007 + 32'(8*f), 16'hFFFF, 1'b1));
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 160; i++) begin
      send(32'h1000 + 32'(i), 32'h300);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    wait_drain("random_backpressure");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    chk("seq_after_random", seq, 24);

    // Reset after the header and three tags abandons the frame.
    exp_q.push_back(mk_hdr(32'd24, 32'h400));
    for (int i = 0; i < 3; i++) send(32'h41 + 32'(i), 32'h400);
    wait_drain("pre_reset_header");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_seq", seq, 0);
    chk("reset_s_ready", s_ready, 0);
    rst = 1'b0;
    exp_q.push_back(mk_hdr(32'd0, 32'h500));
    exp_q.push_back(mk_pay(32'h51, 32'h52, 32'h53, 32'h54, 16'hFFFF, 1'b0));
    exp_q.push_back(mk_pay(32'h55, 32'h56, 32'h57, 32'h58, 16'hFFFF, 1'b1));
    for (int i = 0; i < 8; i++) send(32'h51 + 32'(i), 32'h500);
    wait_drain("post_reset_frame");
    chk("seq_after_reset_frame", seq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
